// File: rtl/seg7_mux_conv.sv
// Captures a value, converts it (hex, decimal, gray encode, gray decode) and
// time-multiplexes the result onto common-anode seven-segment digits.
module seg7_mux_conv #(
    parameter int N_DIGITS   = 4,
    parameter int IN_WIDTH   = 14,
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLANK_LZ   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] value,
    input  logic [1:0]          mode,
    input  logic                load,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [N_DIGITS-1:0] anodo,
    output logic [6:0]          catodo
);

    localparam int TICK_DIV   = CLK_HZ / (REFRESH_HZ * N_DIGITS);
    localparam int TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    // floor(IN_WIDTH*log10(2))+1 decimal digits; 3/10 is exact enough up to 26 bits
    localparam int BCD_DIGITS = (IN_WIDTH * 3) / 10 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DD_W       = BCD_W + IN_WIDTH;
    localparam int HEX_DIGITS = ((IN_WIDTH + 3) / 4 > N_DIGITS) ? (IN_WIDTH + 3) / 4 : N_DIGITS;
    localparam int DEC_DIGITS = (BCD_DIGITS > N_DIGITS) ? BCD_DIGITS : N_DIGITS;
    localparam int HEX_W      = 4 * HEX_DIGITS;
    localparam int DEC_W      = 4 * DEC_DIGITS;
    localparam int CNT_W      = $clog2(IN_WIDTH + 1);

    localparam logic [CNT_W-1:0]  ITER_LAST   = CNT_W'(IN_WIDTH - 1);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]        GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0]        GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t                         state_reg, state_next;
    logic                           busy_reg, busy_next;
    logic                           done_reg, done_next;
    logic                           dec_mode_reg;
    logic [IN_WIDTH-1:0]            val_reg;
    logic [DD_W-1:0]                dd_reg, dd_adj;
    logic [CNT_W-1:0]               iter_cnt_reg;
    logic [N_DIGITS-1:0][3:0]       disp_reg;
    logic                           ovf_reg;
    logic [4*N_DIGITS-1:0]          disp_next;
    logic                           ovf_next;
    logic [IN_WIDTH-1:0]            gray_enc, gray_dec, sel_val;
    logic [HEX_W-1:0]               hex_ext;
    logic [DEC_W-1:0]               dec_ext;
    logic [N_DIGITS-1:0]            blank_vec;
    logic [TICK_W-1:0]              tick_reg;
    logic [IDX_W-1:0]               digit_idx_reg;
    logic [N_DIGITS-1:0]            anodo_reg;
    logic [6:0]                     catodo_reg;
    logic [6:0]                     glyph_next;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    // Input-side code conversions, resolved before capture
    assign gray_enc = value ^ (value >> 1);

    generate
        for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_gray_dec
            assign gray_dec[gi] = ^(value >> gi);
        end
    endgenerate

    always_comb begin
        sel_val = value;
        case (mode)
            2'd2:    sel_val = gray_enc;
            2'd3:    sel_val = gray_dec;
            default: sel_val = value;
        endcase
    end

    // Double-dabble correction: +3 on every BCD nibble >= 5 before the shift
    assign dd_adj[IN_WIDTH-1:0] = dd_reg[IN_WIDTH-1:0];
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dabble
            assign dd_adj[IN_WIDTH+4*gi +: 4] =
                (dd_reg[IN_WIDTH+4*gi +: 4] >= 4'd5) ? dd_reg[IN_WIDTH+4*gi +: 4] + 4'd3
                                                     : dd_reg[IN_WIDTH+4*gi +: 4];
        end
    endgenerate

    assign hex_ext   = HEX_W'(val_reg);
    assign dec_ext   = DEC_W'(dd_reg[DD_W-1 -: BCD_W]);
    assign disp_next = dec_mode_reg ? dec_ext[4*N_DIGITS-1:0] : hex_ext[4*N_DIGITS-1:0];
    assign ovf_next  = dec_mode_reg ? |(dec_ext >> (4 * N_DIGITS)) : |(hex_ext >> (4 * N_DIGITS));

    always_comb begin
        state_next = state_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    if (mode[0]) begin
                        state_next = SHIFT;
                        busy_next  = 1'b1;
                    end else begin
                        state_next = FINISH;
                    end
                end
            end
            SHIFT: begin
                if (iter_cnt_reg == ITER_LAST) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            dec_mode_reg <= 1'b0;
            val_reg      <= '0;
            dd_reg       <= '0;
            iter_cnt_reg <= '0;
            disp_reg     <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        dec_mode_reg <= mode[0];
                        val_reg      <= sel_val;
                        dd_reg       <= {{BCD_W{1'b0}}, sel_val};
                        iter_cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    dd_reg       <= dd_adj << 1;
                    iter_cnt_reg <= iter_cnt_reg + 1'b1;
                end
                FINISH: begin
                    disp_reg <= disp_next;
                    ovf_reg  <= ovf_next;
                end
                default: ;
            endcase
        end
    end

    // A digit is blank when it and every digit above it are zero
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blank_vec[gi] = 1'b0;
            end else begin : g_upper
                assign blank_vec[gi] = (BLANK_LZ != 0) && (disp_reg[N_DIGITS-1:gi] == '0);
            end
        end
    endgenerate

    always_comb begin
        glyph_next = hex_glyph(disp_reg[digit_idx_reg]);
        if (blank_vec[digit_idx_reg]) begin
            glyph_next = GLYPH_BLANK;
        end
        if (ovf_reg) begin
            glyph_next = GLYPH_DASH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_reg      <= '0;
            digit_idx_reg <= '0;
            anodo_reg     <= '1;
            catodo_reg    <= GLYPH_BLANK;
        end else begin
            anodo_reg  <= ~(N_DIGITS'(1) << digit_idx_reg);
            catodo_reg <= glyph_next;
            if (tick_reg == TICK_LAST) begin
                tick_reg      <= '0;
                digit_idx_reg <= (digit_idx_reg == IDX_LAST) ? '0 : digit_idx_reg + 1'b1;
            end else begin
                tick_reg <= tick_reg + 1'b1;
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign overflow = ovf_reg;
    assign anodo    = anodo_reg;
    assign catodo   = catodo_reg;

endmodule

// File: tb/tb_seg7_mux_conv.sv
// Directed bench for seg7_mux_conv: one instance without and one with
// leading-zero blanking, both at 4 clocks per digit.
module tb_seg7_mux_conv;

    localparam int ND = 4;
    localparam int IW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] value = '0;
    logic [1:0]    mode = '0;
    logic          load = 1'b0;

    logic          busy0, done0, ovf0, busy1, done1, ovf1;
    logic [ND-1:0] an0, an1;
    logic [6:0]    cat0, cat1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_mux_conv #(.N_DIGITS(ND), .IN_WIDTH(IW), .CLK_HZ(16000), .REFRESH_HZ(1000), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst(rst), .value(value), .mode(mode), .load(load),
        .busy(busy0), .done(done0), .overflow(ovf0), .anodo(an0), .catodo(cat0)
    );

    seg7_mux_conv #(.N_DIGITS(ND), .IN_WIDTH(IW), .CLK_HZ(16000), .REFRESH_HZ(1000), .BLANK_LZ(1)) dut1 (
        .clk(clk), .rst(rst), .value(value), .mode(mode), .load(load),
        .busy(busy1), .done(done1), .overflow(ovf1), .anodo(an1), .catodo(cat1)
    );

    typedef struct {
        logic [IW-1:0]         value;
        logic [1:0]            mode;
        logic [ND-1:0][6:0]    exp0;
        logic [ND-1:0][6:0]    exp1;
        logic                  ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Collect the glyph shown on each digit over one full refresh
    task automatic read_glyphs(output logic [ND-1:0][6:0] g0, output logic [ND-1:0][6:0] g1,
                               output int bad_an);
        g0 = 'x;
        g1 = 'x;
        bad_an = 0;
        @(negedge clk);
        for (int c = 0; c < ND * 4; c++) begin
            @(negedge clk);
            if ($countones(~an0) != 1 || $countones(~an1) != 1) bad_an++;
            for (int d = 0; d < ND; d++) begin
                if (an0 == ~(ND'(1) << d)) g0[d] = cat0;
                if (an1 == ~(ND'(1) << d)) g1[d] = cat1;
            end
        end
    endtask

    task automatic load_and_wait(input logic [IW-1:0] v, input logic [1:0] m,
                                 output int lat, output int bcnt);
        value = v;
        mode  = m;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int c = 0; c <= 40; c++) begin
            if (busy0) bcnt++;
            if (done0) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_display(input string tag, input logic [ND-1:0][6:0] e0,
                                 input logic [ND-1:0][6:0] e1);
        logic [ND-1:0][6:0] g0, g1;
        int bad;
        read_glyphs(g0, g1, bad);
        chk({tag, "_anodo_onehot"}, bad, 0);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s_dig%0d", tag, d), g0[d], e0[d]);
            chk($sformatf("%s_blank_dig%0d", tag, d), g1[d], e1[d]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, bcnt, cyc, dcnt;
        logic [ND-1:0] exp_an;

        vecs[0]  = '{14'h1A3F, 2'd0, {7'h79, 7'h08, 7'h30, 7'h0E}, {7'h79, 7'h08, 7'h30, 7'h0E}, 1'b0};
        vecs[1]  = '{14'd9999, 2'd1, {7'h10, 7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10, 7'h10}, 1'b0};
        vecs[2]  = '{14'd10000, 2'd1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        vecs[3]  = '{14'd5, 2'd2, {7'h40, 7'h40, 7'h40, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0};
        vecs[4]  = '{14'd7, 2'd3, {7'h40, 7'h40, 7'h40, 7'h12}, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b0};
        vecs[5]  = '{14'd42, 2'd1, {7'h40, 7'h40, 7'h19, 7'h24}, {7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0};
        vecs[6]  = '{14'd0, 2'd1, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
        vecs[7]  = '{14'h3FFF, 2'd0, {7'h30, 7'h0E, 7'h0E, 7'h0E}, {7'h30, 7'h0E, 7'h0E, 7'h0E}, 1'b0};
        vecs[8]  = '{14'd16383, 2'd1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        vecs[9]  = '{14'h2000, 2'd2, {7'h30, 7'h40, 7'h40, 7'h40}, {7'h30, 7'h40, 7'h40, 7'h40}, 1'b0};
        vecs[10] = '{14'd15, 2'd3, {7'h40, 7'h40, 7'h79, 7'h40}, {7'h7F, 7'h7F, 7'h79, 7'h40}, 1'b0};

        // Reset, run a little, then assert reset between clock edges
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_anodo", an0, 4'hF);
        chk("rst_catodo", cat0, 7'h7F);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_overflow", ovf0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            exp_an = ~(ND'(1) << (((e - 1) / 4) % ND));
            chk($sformatf("scan_edge%0d", e), an0, exp_an);
            if (e == 1) chk("scan_first_catodo", cat0, 7'b1000000);
        end

        // Table-driven conversions
        for (int i = 0; i < 11; i++) begin
            load_and_wait(vecs[i].value, vecs[i].mode, lat, bcnt);
            $display("vec %0d value=%0d mode=%0d latency=%0d busy_cycles=%0d ovf=%0b",
                     i, vecs[i].value, vecs[i].mode, lat, bcnt, ovf0);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].mode[0] ? IW + 1 : 1);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].mode[0] ? IW + 1 : 0);
            chk($sformatf("v%0d_overflow", i), ovf0, vecs[i].ovf);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done0, 0);
            check_display($sformatf("v%0d", i), vecs[i].exp0, vecs[i].exp1);
        end

        // load during SHIFT is dropped, not queued
        value = 14'd1234;
        mode  = 2'd1;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc  = 0;
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        value = 14'd100;
        load  = 1'b1;
        @(negedge clk);
        cyc++;
        load = 1'b0;
        while (!done0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        $display("robust load-during-shift latency=%0d", cyc);
        chk("ignore_load_latency", cyc, IW + 1);
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0) dcnt++;
        end
        chk("ignore_load_no_second_done", dcnt, 0);
        check_display("ignore_load", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19});

        // Reset in the middle of a conversion discards it
        value = 14'd1234;
        mode  = 2'd1;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", busy0, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_anodo", an0, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0) dcnt++;
        end
        $display("robust reset-during-shift done_count=%0d busy=%0b", dcnt, busy0);
        chk("rst_shift_no_done", dcnt, 0);
        chk("rst_shift_busy", busy0, 0);
        chk("rst_shift_overflow", ovf0, 0);
        check_display("rst_shift", {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
